id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding front end for the ALU.
//  - Captures decoded control and operands from ID.
//  - Resolves EX/MEM and MEM/WB forwarding, then drives operand_a/operand_b/alu_op into alu.
//  - Detects load-use hazards, requests an upstream stall and inserts the bubble itself.

---
 rtl/id_ex_stage_pkg.sv | 64 ++++++
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage_fwd_unit.sv | 26 ++
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU opcodes, forwarding selects,
// the packed pipeline register and the forwarding mux helper.
package id_ex_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_AND  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        alu_op_t               alu_op;
        logic                  a_sel_pc;
        logic                  b_sel_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } id_ex_t;

    // All-zero register image: invalid, ALU_NOP, no side effects.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic [XLEN-1:0] fwd_mux(
        input fwd_sel_t        sel,
        input logic [XLEN-1:0] rf_data,
        input logic [XLEN-1:0] exmem_data,
        input logic [XLEN-1:0] memwb_data
    );
        logic [XLEN-1:0] res;
        case (sel)
            FWD_EXMEM: res = exmem_data;
            FWD_MEMWB: res = memwb_data;
            default:   res = rf_data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every ID-side input, EX/MEM and MEM/WB bypass input and
// EX-side output of the ID/EX stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic                  flush_i;
    logic                  stall_i;
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    alu_op_t               id_alu_op;
    logic                  id_a_sel_pc;
    logic                  id_b_sel_imm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic [REG_ADDR_W-1:0] exmem_rd_addr;
    logic                  exmem_reg_write;
    logic [XLEN-1:0]       exmem_result;
    logic [REG_ADDR_W-1:0] memwb_rd_addr;
    logic                  memwb_reg_write;
    logic [XLEN-1:0]       memwb_result;

    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    alu_op_t               alu_op;
    logic [XLEN-1:0]       ex_store_data;
    logic [XLEN-1:0]       ex_pc;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_valid;
    logic                  load_use_stall;

    // Pipeline side that drives ID/bypass inputs and consumes EX outputs.
    modport master (
        output flush_i, stall_i, id_valid, id_pc, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_alu_op,
               id_a_sel_pc, id_b_sel_imm, id_reg_write, id_mem_read,
               id_mem_write, exmem_rd_addr, exmem_reg_write, exmem_result,
               memwb_rd_addr, memwb_reg_write, memwb_result,
        input  operand_a, operand_b, alu_op, ex_store_data, ex_pc,
               ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_valid, load_use_stall
    );

    // The ID/EX stage itself.
    modport slave (
        input  flush_i, stall_i, id_valid, id_pc, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_alu_op,
               id_a_sel_pc, id_b_sel_imm, id_reg_write, id_mem_read,
               id_mem_write, exmem_rd_addr, exmem_reg_write, exmem_result,
               memwb_rd_addr, memwb_reg_write, memwb_result,
        output operand_a, operand_b, alu_op, ex_store_data, ex_pc,
               ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_valid, load_use_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Picks the bypass source for one EX source register. EX/MEM is the
// younger producer so it wins over MEM/WB; x0 is hardwired and never bypassed.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr_i,
    input  logic                  memwb_reg_write_i,
    output fwd_sel_t              sel_o
);

    // Priority compare: EX/MEM, then MEM/WB, else register-file data.
    always_comb begin
        sel_o = FWD_NONE;
        if (rs_addr_i != '0) begin
            if (exmem_reg_write_i && (exmem_rd_addr_i == rs_addr_i)) begin
                sel_o = FWD_EXMEM;
            end else if (memwb_reg_write_i && (memwb_rd_addr_i == rs_addr_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble
// insertion in front of the ALU.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    id_ex_t          capture;
    logic            load_use;
    fwd_sel_t        sel_rs1;
    fwd_sel_t        sel_rs2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load in EX whose rd is read by the instruction in ID; a flush overrides it.
    assign load_use = ~bus.flush_i & ex_q.valid & ex_q.mem_read &
                      (ex_q.rd_addr != '0) &
                      ((bus.id_rs1_addr == ex_q.rd_addr) |
                       (bus.id_rs2_addr == ex_q.rd_addr));

    // Build the captured image; side-effecting controls only for real instructions.
    always_comb begin
        capture           = ID_EX_BUBBLE;
        capture.valid     = bus.id_valid;
        capture.pc        = bus.id_pc;
        capture.rs1_addr  = bus.id_rs1_addr;
        capture.rs2_addr  = bus.id_rs2_addr;
        capture.rd_addr   = bus.id_rd_addr;
        capture.rs1_data  = bus.id_rs1_data;
        capture.rs2_data  = bus.id_rs2_data;
        capture.imm       = bus.id_imm;
        capture.alu_op    = bus.id_valid ? bus.id_alu_op : ALU_NOP;
        capture.a_sel_pc  = bus.id_a_sel_pc;
        capture.b_sel_imm = bus.id_b_sel_imm;
        capture.reg_write = bus.id_reg_write & bus.id_valid;
        capture.mem_read  = bus.id_mem_read  & bus.id_valid;
        capture.mem_write = bus.id_mem_write & bus.id_valid;
    end

    // Next-state priority: flush, then downstream stall, then load-use bubble, then capture.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush_i) begin
            ex_d = ID_EX_BUBBLE;
        end else if (bus.stall_i) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = ID_EX_BUBBLE;
        end else begin
            ex_d = capture;
        end
    end

    // Pipeline register; async reset leaves a bubble so every output reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= ID_EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    id_ex_stage_fwd_unit u_fwd_rs1 (
        .rs_addr_i         (ex_q.rs1_addr),
        .exmem_rd_addr_i   (bus.exmem_rd_addr),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .memwb_rd_addr_i   (bus.memwb_rd_addr),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .sel_o             (sel_rs1)
    );

    id_ex_stage_fwd_unit u_fwd_rs2 (
        .rs_addr_i         (ex_q.rs2_addr),
        .exmem_rd_addr_i   (bus.exmem_rd_addr),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .memwb_rd_addr_i   (bus.memwb_rd_addr),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .sel_o             (sel_rs2)
    );

    assign fwd_rs1 = fwd_mux(sel_rs1, ex_q.rs1_data, bus.exmem_result, bus.memwb_result);
    assign fwd_rs2 = fwd_mux(sel_rs2, ex_q.rs2_data, bus.exmem_result, bus.memwb_result);

    assign bus.operand_a      = ex_q.a_sel_pc  ? ex_q.pc  : fwd_rs1;
    assign bus.operand_b      = ex_q.b_sel_imm ? ex_q.imm : fwd_rs2;
    assign bus.alu_op         = ex_q.alu_op;
    // Stores always take the forwarded rs2, even when operand_b is the immediate.
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_rd_addr     = ex_q.rd_addr;
    assign bus.ex_reg_write   = ex_q.reg_write & ex_q.valid;
    assign bus.ex_mem_read    = ex_q.mem_read  & ex_q.valid;
    assign bus.ex_mem_write   = ex_q.mem_write & ex_q.valid;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the EX stage is supposed to hold, kept as plain fields.
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        asel;
        logic        bsel;
        logic        rw;
        logic        mr;
        logic        mw;
    } m_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        v;
        logic        lus;
    } out_t;

    m_t m;

    function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (bus.exmem_reg_write && bus.exmem_rd_addr == rs) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd_addr == rs) return bus.memwb_result;
        return rf;
    endfunction

    function automatic logic exp_stall();
        return !bus.flush_i && m.v && m.mr && (m.rd != 5'd0) &&
               (bus.id_rs1_addr == m.rd || bus.id_rs2_addr == m.rd);
    endfunction

    function automatic out_t expected();
        out_t e;
        e.a   = m.asel ? m.pc : fwd_val(m.rs1, m.d1);
        e.b   = m.bsel ? m.imm : fwd_val(m.rs2, m.d2);
        e.op  = m.op;
        e.sd  = fwd_val(m.rs2, m.d2);
        e.pc  = m.pc;
        e.rd  = m.rd;
        e.rw  = m.rw;
        e.mr  = m.mr;
        e.mw  = m.mw;
        e.v   = m.v;
        e.lus = exp_stall();
        return e;
    endfunction

    function automatic out_t observed();
        out_t o;
        o.a   = bus.operand_a;
        o.b   = bus.operand_b;
        o.op  = bus.alu_op;
        o.sd  = bus.ex_store_data;
        o.pc  = bus.ex_pc;
        o.rd  = bus.ex_rd_addr;
        o.rw  = bus.ex_reg_write;
        o.mr  = bus.ex_mem_read;
        o.mw  = bus.ex_mem_write;
        o.v   = bus.ex_valid;
        o.lus = bus.load_use_stall;
        return o;
    endfunction

    // One clock edge: advance the model from the inputs present before the edge.
    task automatic tick();
        m_t nxt;
        nxt = m;
        if (bus.flush_i) begin
            nxt = '0;
        end else if (!bus.stall_i) begin
            if (exp_stall()) begin
                nxt = '0;
            end else begin
                nxt.v    = bus.id_valid;
                nxt.pc   = bus.id_pc;
                nxt.rs1  = bus.id_rs1_addr;
                nxt.rs2  = bus.id_rs2_addr;
                nxt.rd   = bus.id_rd_addr;
                nxt.d1   = bus.id_rs1_data;
                nxt.d2   = bus.id_rs2_data;
                nxt.imm  = bus.id_imm;
                nxt.op   = bus.id_valid ? bus.id_alu_op : ALU_NOP;
                nxt.asel = bus.id_a_sel_pc;
                nxt.bsel = bus.id_b_sel_imm;
                nxt.rw   = bus.id_reg_write & bus.id_valid;
                nxt.mr   = bus.id_mem_read & bus.id_valid;
                nxt.mw   = bus.id_mem_write & bus.id_valid;
            end
        end
        @(posedge clk);
        m = rst ? '0 : nxt;
        #1;
    endtask

    task automatic idle();
        bus.flush_i         = 1'b0;
        bus.stall_i         = 1'b0;
        bus.id_valid        = 1'b0;
        bus.id_pc           = '0;
        bus.id_rs1_addr     = '0;
        bus.id_rs2_addr     = '0;
        bus.id_rd_addr      = '0;
        bus.id_rs1_data     = '0;
        bus.id_rs2_data     = '0;
        bus.id_imm          = '0;
        bus.id_alu_op       = ALU_NOP;
        bus.id_a_sel_pc     = 1'b0;
        bus.id_b_sel_imm    = 1'b0;
        bus.id_reg_write    = 1'b0;
        bus.id_mem_read     = 1'b0;
        bus.id_mem_write    = 1'b0;
        bus.exmem_rd_addr   = '0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_result    = '0;
        bus.memwb_rd_addr   = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_result    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.exmem_result = 32'hDEAD_BEEF;
        bus.memwb_result = 32'hCAFE_F00D;
        m = '0;
        #12;
        n_cmp++;
        if (observed() !== out_t'(0)) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", observed());
        end
        n_cmp++;
        if (bus.alu_op !== ALU_NOP) begin
            n_bad++;
            $display("FAIL reset_alu_op: got %0d want %0d", bus.alu_op, ALU_NOP);
        end
        rst = 1'b0;
        bus.exmem_result = '0;
        bus.memwb_result = '0;
    endtask

    task automatic test_capture();
        idle();
        bus.id_valid     = 1'b1;
        bus.id_alu_op    = ALU_ADD;
        bus.id_pc        = 32'h40;
        bus.id_rs1_addr  = 5'd1;
        bus.id_rs2_addr  = 5'd2;
        bus.id_rd_addr   = 5'd7;
        bus.id_rs1_data  = 32'd5;
        bus.id_rs2_data  = 32'd10;
        bus.id_reg_write = 1'b1;
        tick();
        n_cmp++;
        if (bus.operand_a !== 32'd5 || bus.operand_b !== 32'd10 || bus.alu_op !== ALU_ADD) begin
            n_bad++;
            $display("FAIL capture_add: got a=%0d b=%0d op=%0d want a=5 b=10 op=%0d",
                     bus.operand_a, bus.operand_b, bus.alu_op, ALU_ADD);
        end
        n_cmp++;
        if (observed() !== expected()) begin
            n_bad++;
            $display("FAIL capture_all: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_forwarding();
        idle();
        bus.id_valid    = 1'b1;
        bus.id_alu_op   = ALU_ADD;
        bus.id_rs1_addr = 5'd3;
        bus.id_rs1_data = 32'h99;
        bus.id_rs2_addr = 5'd4;
        bus.id_rs2_data = 32'h7;
        tick();
        bus.exmem_rd_addr   = 5'd3;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_result    = 32'h11;
        bus.memwb_rd_addr   = 5'd3;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_result    = 32'h22;
        #1;
        n_cmp++;
        if (bus.operand_a !== 32'h11) begin
            n_bad++;
            $display("FAIL fwd_exmem_wins: got %h want 11", bus.operand_a);
        end
        bus.exmem_reg_write = 1'b0;
        #1;
        n_cmp++;
        if (bus.operand_a !== 32'h22) begin
            n_bad++;
            $display("FAIL fwd_memwb: got %h want 22", bus.operand_a);
        end
        bus.memwb_reg_write = 1'b0;
        bus.exmem_rd_addr   = 5'd4;
        bus.exmem_reg_write = 1'b1;
        #1;
        n_cmp++;
        if (bus.operand_a !== 32'h99 || bus.ex_store_data !== 32'h11 || bus.operand_b !== 32'h11) begin
            n_bad++;
            $display("FAIL fwd_rs2: got a=%h b=%h sd=%h want a=99 b=11 sd=11",
                     bus.operand_a, bus.operand_b, bus.ex_store_data);
        end
        bus.id_rs1_addr     = 5'd0;
        bus.id_rs1_data     = 32'h55;
        bus.exmem_rd_addr   = 5'd0;
        bus.exmem_reg_write = 1'b1;
        bus.memwb_rd_addr   = 5'd0;
        bus.memwb_reg_write = 1'b1;
        tick();
        n_cmp++;
        if (bus.operand_a !== 32'h55) begin
            n_bad++;
            $display("FAIL fwd_x0: got %h want 55", bus.operand_a);
        end
    endtask

    task automatic test_load_use();
        idle();
        bus.id_valid     = 1'b1;
        bus.id_alu_op    = ALU_ADD;
        bus.id_mem_read  = 1'b1;
        bus.id_reg_write = 1'b1;
        bus.id_rd_addr   = 5'd5;
        bus.id_rs1_addr  = 5'd1;
        bus.id_imm       = 32'd4;
        tick();
        bus.id_mem_read  = 1'b0;
        bus.id_rs1_addr  = 5'd1;
        bus.id_rs2_addr  = 5'd5;
        bus.id_rd_addr   = 5'd6;
        #1;
        n_cmp++;
        if (bus.load_use_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL load_use_raise: got %b want 1", bus.load_use_stall);
        end
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_NOP || bus.load_use_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL load_use_bubble: got v=%b op=%0d lus=%b want v=0 op=0 lus=0",
                     bus.ex_valid, bus.alu_op, bus.load_use_stall);
        end
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b1 || bus.alu_op !== ALU_ADD || bus.ex_rd_addr !== 5'd6) begin
            n_bad++;
            $display("FAIL load_use_resume: got v=%b op=%0d rd=%0d want v=1 op=%0d rd=6",
                     bus.ex_valid, bus.alu_op, bus.ex_rd_addr, ALU_ADD);
        end
    endtask

    task automatic test_flush_stall();
        idle();
        bus.id_valid     = 1'b1;
        bus.id_alu_op    = ALU_SUB;
        bus.id_pc        = 32'h200;
        bus.id_rd_addr   = 5'd9;
        bus.id_reg_write = 1'b1;
        tick();
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_NOP || bus.ex_reg_write !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_over_stall: got v=%b op=%0d rw=%b want 0 0 0",
                     bus.ex_valid, bus.alu_op, bus.ex_reg_write);
        end
        bus.flush_i     = 1'b0;
        bus.stall_i     = 1'b0;
        bus.id_pc       = 32'h300;
        bus.id_alu_op   = ALU_XOR;
        bus.id_rd_addr  = 5'd10;
        bus.id_rs1_addr = 5'd2;
        bus.id_rs1_data = 32'h1234;
        tick();
        bus.id_pc      = 32'h999;
        bus.id_alu_op  = ALU_AND;
        bus.id_rd_addr = 5'd11;
        bus.stall_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.ex_pc !== 32'h300 || bus.alu_op !== ALU_XOR || bus.ex_rd_addr !== 5'd10 ||
                bus.operand_a !== 32'h1234 || observed() !== expected()) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, observed(), expected());
            end
        end
        bus.stall_i = 1'b0;
    endtask

    task automatic test_lui_auipc();
        idle();
        bus.id_valid     = 1'b1;
        bus.id_alu_op    = ALU_LUI;
        bus.id_b_sel_imm = 1'b1;
        bus.id_imm       = 32'hABCD_E000;
        bus.id_rs2_addr  = 5'd8;
        bus.id_rs2_data  = 32'h5;
        tick();
        n_cmp++;
        if (bus.operand_b !== 32'hABCD_E000 || bus.alu_op !== ALU_LUI || bus.ex_store_data !== 32'h5) begin
            n_bad++;
            $display("FAIL lui_imm: got b=%h op=%0d sd=%h want b=abcde000 op=%0d sd=5",
                     bus.operand_b, bus.alu_op, bus.ex_store_data, ALU_LUI);
        end
        bus.id_alu_op   = ALU_ADD;
        bus.id_a_sel_pc = 1'b1;
        bus.id_pc       = 32'h100;
        bus.id_imm      = 32'h4;
        bus.id_rs1_addr = 5'd1;
        bus.id_rs1_data = 32'h77;
        tick();
        n_cmp++;
        if (bus.operand_a !== 32'h100 || bus.operand_b !== 32'h4) begin
            n_bad++;
            $display("FAIL auipc_pc: got a=%h b=%h want a=100 b=4", bus.operand_a, bus.operand_b);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.flush_i         = ($urandom_range(0, 15) == 0);
            bus.stall_i         = ($urandom_range(0, 7) == 0);
            bus.id_valid        = ($urandom_range(0, 3) != 0);
            bus.id_pc           = $urandom;
            bus.id_rs1_addr     = 5'($urandom_range(0, 7));
            bus.id_rs2_addr     = 5'($urandom_range(0, 7));
            bus.id_rd_addr      = 5'($urandom_range(0, 7));
            bus.id_rs1_data     = $urandom;
            bus.id_rs2_data     = $urandom;
            bus.id_imm          = $urandom;
            bus.id_alu_op       = alu_op_t'(4'($urandom_range(0, 11)));
            bus.id_a_sel_pc     = 1'($urandom_range(0, 1));
            bus.id_b_sel_imm    = 1'($urandom_range(0, 1));
            bus.id_reg_write    = 1'($urandom_range(0, 1));
            bus.id_mem_read     = 1'($urandom_range(0, 1));
            bus.id_mem_write    = 1'($urandom_range(0, 1));
            bus.exmem_rd_addr   = 5'($urandom_range(0, 7));
            bus.exmem_reg_write = 1'($urandom_range(0, 1));
            bus.exmem_result    = $urandom;
            bus.memwb_rd_addr   = 5'($urandom_range(0, 7));
            bus.memwb_reg_write = 1'($urandom_range(0, 1));
            bus.memwb_result    = $urandom;
            #1;
            n_cmp++;
            if (bus.load_use_stall !== exp_stall()) begin
                n_bad++;
                $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.load_use_stall, exp_stall());
            end
            tick();
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL rand_out[%0d]: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_async_reset();
        idle();
        bus.id_valid     = 1'b1;
        bus.id_alu_op    = ALU_OR;
        bus.id_a_sel_pc  = 1'b1;
        bus.id_pc        = 32'h4000;
        bus.id_rd_addr   = 5'd3;
        bus.id_mem_read  = 1'b1;
        bus.id_reg_write = 1'b1;
        tick();
        bus.stall_i          = 1'b1;
        bus.exmem_reg_write  = 1'b1;
        bus.exmem_rd_addr    = 5'd1;
        bus.exmem_result     = 32'h1111;
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (observed() !== out_t'(0) || bus.alu_op !== ALU_NOP) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", observed());
        end
        m = '0;
        #2;
        rst = 1'b0;
        idle();
        bus.id_valid    = 1'b1;
        bus.id_alu_op   = ALU_SLT;
        bus.id_rs1_addr = 5'd2;
        bus.id_rs1_data = 32'hF0;
        bus.id_rd_addr  = 5'd4;
        tick();
        n_cmp++;
        if (observed() !== expected() || bus.operand_a !== 32'hF0) begin
            n_bad++;
            $display("FAIL after_reset: got %h want %h", observed(), expected());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_capture();
        test_forwarding();
        test_load_use();
        test_flush_stall();
        test_lui_auipc();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
